sprite_pos_scheduler: RTL

Frame-synchronous position update controller between the SPI link from the microcontroller and the circle/sprite drawing datapath in the VGA pipeline. It synchronises the asynchronous SPI clock and data into the `vgaclk` domain and assembles 32-bit `{x[15:0], y[15:0]}` words. Each word is clamped to the visible area and held in a shadow register. The shadow value is committed to the drawing datapath only at the start of vertical sync, so a position never changes mid-frame (no tearing).

---
 rtl/sprite_pos_scheduler.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sprite_pos_scheduler.sv
// Receives {x,y} position words over SPI, clamps them to the visible area and
// commits them to the drawing datapath only at the start of vertical sync.
module sprite_pos_scheduler #(
   parameter int WIDTH   = 640,
   parameter int HEIGHT  = 480,
   parameter int X_RESET = 320,
   parameter int Y_RESET = 240,
   parameter int TIMEOUT = 1024
) (
   input  logic       vgaclk,
   input  logic       reset_b,
   input  logic       sck,
   input  logic       sdi,
   input  logic       vsync,
   output logic [9:0] xpos,
   output logic [9:0] ypos,
   output logic       pos_valid,
   output logic       pending,
   output logic       frame_strobe,
   output logic [7:0] overrun_cnt
);

   localparam int TW = $clog2(TIMEOUT) + 1;

   typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_t;
   typedef enum logic {CM_EMPTY, CM_FULL} cm_state_t;

   rx_state_t   rx_state_reg;
   cm_state_t   cm_state_reg;
   logic [1:0]  sck_sync_reg;
   logic [1:0]  sdi_sync_reg;
   logic        sck_prev_reg;
   logic [4:0]  bitcnt_reg;
   logic [TW-1:0] timer_reg;
   logic [31:0] q_reg;
   logic        word_done_reg;
   logic        vsync_reg;
   logic [9:0]  shadow_x_reg;
   logic [9:0]  shadow_y_reg;

   logic        fall;
   logic        sdi_bit;
   logic        vs_fall;
   logic [9:0]  xc;
   logic [9:0]  yc;

   assign fall    = sck_prev_reg & ~sck_sync_reg[1];
   assign sdi_bit = sdi_sync_reg[1];
   assign vs_fall = vsync_reg & ~vsync;
   assign pending = (cm_state_reg == CM_FULL);

   // Out-of-range coordinates pin to the last visible column/row.
   assign xc = (q_reg[31:16] >= 16'(WIDTH))  ? 10'(WIDTH - 1)  : q_reg[25:16];
   assign yc = (q_reg[15:0]  >= 16'(HEIGHT)) ? 10'(HEIGHT - 1) : q_reg[9:0];

   always_ff @(posedge vgaclk or negedge reset_b) begin
      if (!reset_b) begin
         sck_sync_reg <= 2'b00;
         sdi_sync_reg <= 2'b00;
         sck_prev_reg <= 1'b0;
      end else begin
         sck_sync_reg <= {sck_sync_reg[0], sck};
         sdi_sync_reg <= {sdi_sync_reg[0], sdi};
         sck_prev_reg <= sck_sync_reg[1];
      end
   end

   always_ff @(posedge vgaclk or negedge reset_b) begin
      if (!reset_b) begin
         rx_state_reg  <= RX_IDLE;
         bitcnt_reg    <= '0;
         timer_reg     <= '0;
         q_reg         <= '0;
         word_done_reg <= 1'b0;
      end else begin
         word_done_reg <= 1'b0;
         case (rx_state_reg)
            RX_IDLE: begin
               timer_reg <= '0;
               if (fall) begin
                  q_reg        <= {q_reg[30:0], sdi_bit};
                  bitcnt_reg   <= 5'd1;
                  rx_state_reg <= RX_SHIFT;
               end
            end
            RX_SHIFT: begin
               if (fall) begin
                  q_reg     <= {q_reg[30:0], sdi_bit};
                  timer_reg <= '0;
                  if (bitcnt_reg == 5'd31) begin
                     word_done_reg <= 1'b1;
                     bitcnt_reg    <= '0;
                     rx_state_reg  <= RX_IDLE;
                  end else begin
                     bitcnt_reg <= bitcnt_reg + 5'd1;
                  end
               end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                  // Master stalled mid-word: drop the partial word and resync.
                  bitcnt_reg   <= '0;
                  timer_reg    <= '0;
                  rx_state_reg <= RX_IDLE;
               end else begin
                  timer_reg <= timer_reg + TW'(1);
               end
            end
            default: rx_state_reg <= RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge vgaclk or negedge reset_b) begin
      if (!reset_b) begin
         cm_state_reg <= CM_EMPTY;
         vsync_reg    <= 1'b0;
         shadow_x_reg <= '0;
         shadow_y_reg <= '0;
         xpos         <= 10'(X_RESET);
         ypos         <= 10'(Y_RESET);
         pos_valid    <= 1'b0;
         frame_strobe <= 1'b0;
         overrun_cnt  <= '0;
      end else begin
         vsync_reg    <= vsync;
         frame_strobe <= 1'b0;
         if (vs_fall && cm_state_reg == CM_FULL) begin
            xpos         <= shadow_x_reg;
            ypos         <= shadow_y_reg;
            pos_valid    <= 1'b1;
            frame_strobe <= 1'b1;
         end
         if (word_done_reg) begin
            // A word landing on the commit cycle refills a shadow just emptied.
            shadow_x_reg <= xc;
            shadow_y_reg <= yc;
            cm_state_reg <= CM_FULL;
            if (cm_state_reg == CM_FULL && !vs_fall && overrun_cnt != 8'hFF)
               overrun_cnt <= overrun_cnt + 8'd1;
         end else if (vs_fall && cm_state_reg == CM_FULL) begin
            cm_state_reg <= CM_EMPTY;
         end
      end
   end

endmodule
